// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : Fetch/decode/execute sequencer driving the datapath control strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit #(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic [15:0]     IR_in,
    output logic [PC_W-1:0] PC_addr,
    output logic [7:0]      D_Addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_addr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      Alu_s0,
    output logic [3:0]      OutState,
    output logic            Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    state_t          state, next_state;
    logic [11:0]     ir, next_ir;       // opcode is consumed in DECODE, only operands kept
    logic [PC_W-1:0] pc, next_pc;

    logic [7:0] n_d_addr;
    logic       n_d_wr, n_rf_s, n_rf_we, n_halted;
    logic [3:0] n_wa, n_ra, n_rb;
    logic [2:0] n_alu;

    always_comb begin
        next_state = state;
        next_ir    = ir;
        next_pc    = pc;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                next_ir = IR_in[11:0];
                next_pc = pc + PC_W'(1);
                case (IR_in[15:12])
                    OP_STORE: next_state = S_STORE;
                    OP_LOAD:  next_state = S_LOAD_A;
                    OP_ADD:   next_state = S_ADD;
                    OP_SUB:   next_state = S_SUB;
                    OP_HALT:  next_state = S_HALT;
                    default:  next_state = S_NOOP;
                endcase
            end
            S_LOAD_A: next_state = S_LOAD_B;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Outputs are registered: decode them from the state/IR about to be entered
    always_comb begin
        n_d_addr = 8'd0;
        n_d_wr   = 1'b0;
        n_rf_s   = 1'b0;
        n_rf_we  = 1'b0;
        n_wa     = 4'd0;
        n_ra     = 4'd0;
        n_rb     = 4'd0;
        n_alu    = 3'd0;
        n_halted = 1'b0;
        case (next_state)
            S_LOAD_A: begin
                n_d_addr = next_ir[11:4];
                n_rf_s   = 1'b1;
            end
            S_LOAD_B: begin
                n_d_addr = next_ir[11:4];
                n_rf_s   = 1'b1;
                n_rf_we  = 1'b1;
                n_wa     = next_ir[3:0];
            end
            S_STORE: begin
                n_d_wr   = 1'b1;
                n_d_addr = next_ir[7:0];
                n_ra     = next_ir[11:8];
            end
            S_ADD, S_SUB: begin
                n_ra     = next_ir[11:8];
                n_rb     = next_ir[7:4];
                n_wa     = next_ir[3:0];
                n_rf_we  = 1'b1;
                n_alu    = (next_state == S_ADD) ? 3'd1 : 3'd2;
            end
            S_HALT:  n_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= S_INIT;
            ir         <= 12'd0;
            pc         <= '0;
            D_Addr     <= 8'd0;
            D_wr       <= 1'b0;
            RF_s       <= 1'b0;
            RF_W_en    <= 1'b0;
            RF_W_addr  <= 4'd0;
            RF_Ra_addr <= 4'd0;
            RF_Rb_addr <= 4'd0;
            Alu_s0     <= 3'd0;
            Halted     <= 1'b0;
        end else begin
            state      <= next_state;
            ir         <= next_ir;
            pc         <= next_pc;
            D_Addr     <= n_d_addr;
            D_wr       <= n_d_wr;
            RF_s       <= n_rf_s;
            RF_W_en    <= n_rf_we;
            RF_W_addr  <= n_wa;
            RF_Ra_addr <= n_ra;
            RF_Rb_addr <= n_rb;
            Alu_s0     <= n_alu;
            Halted     <= n_halted;
        end
    end

    assign PC_addr  = pc;
    assign OutState = state;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Self-checking bench for control_unit with a synchronous ROM model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        clk = 1'b0;
    logic        ResetN = 1'b0;
    logic [15:0] IR_in;
    logic [6:0]  PC_addr;
    logic [7:0]  D_Addr;
    logic        D_wr, RF_s, RF_W_en, Halted;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
    logic [2:0]  Alu_s0;

    logic [15:0] rom [0:127];
    int total = 0;
    int bad   = 0;

    control_unit #(.PC_W(7)) dut (
        .Clk(clk), .ResetN(ResetN), .IR_in(IR_in), .PC_addr(PC_addr),
        .D_Addr(D_Addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
        .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .Alu_s0(Alu_s0), .OutState(OutState), .Halted(Halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) IR_in <= rom[PC_addr];

    typedef struct packed {
        logic [3:0] st;
        logic [6:0] pc;
        logic [7:0] da;
        logic       dw;
        logic       rs;
        logic       we;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       hl;
    } obs_t;

    typedef struct {
        logic [15:0] ins;
        int          cyc;
        obs_t        exp;
        logic [3:0]  nxt;
    } vec_t;

    obs_t       q[$];
    logic [6:0] m_pc;
    bit         m_halt;

    function automatic obs_t sample();
        obs_t r;
        r.st = OutState;   r.pc = PC_addr;     r.da = D_Addr;
        r.dw = D_wr;       r.rs = RF_s;        r.we = RF_W_en;
        r.wa = RF_W_addr;  r.ra = RF_Ra_addr;  r.rb = RF_Rb_addr;
        r.alu = Alu_s0;    r.hl = Halted;
        return r;
    endfunction

    function automatic obs_t mk(logic [3:0] st, logic [7:0] da, logic dw, logic rs, logic we,
                                logic [3:0] wa, logic [3:0] ra, logic [3:0] rb,
                                logic [2:0] alu, logic hl);
        obs_t r;
        r.st = st; r.pc = 7'd1; r.da = da; r.dw = dw; r.rs = rs; r.we = we;
        r.wa = wa; r.ra = ra; r.rb = rb; r.alu = alu; r.hl = hl;
        return r;
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Instruction-level reference: one instruction expands into its cycle list
    task automatic expand(input logic [15:0] ins);
        obs_t r;
        logic [6:0] np;
        np = m_pc + 7'd1;
        r = '0;
        r.pc = m_pc;
        r.st = 4'd1; q.push_back(r);
        r.st = 4'd2; q.push_back(r);
        r.pc = np;
        case (ins[15:12])
            4'h1: begin
                r.st = 4'd6; r.dw = 1'b1; r.da = ins[7:0]; r.ra = ins[11:8];
                q.push_back(r);
            end
            4'h2: begin
                r.st = 4'd4; r.da = ins[11:4]; r.rs = 1'b1;
                q.push_back(r);
                r.st = 4'd5; r.we = 1'b1; r.wa = ins[3:0];
                q.push_back(r);
            end
            4'h3, 4'h4: begin
                r.st = (ins[15:12] == 4'h3) ? 4'd7 : 4'd8;
                r.ra = ins[11:8]; r.rb = ins[7:4]; r.wa = ins[3:0];
                r.we = 1'b1; r.alu = (ins[15:12] == 4'h3) ? 3'd1 : 3'd2;
                q.push_back(r);
            end
            4'h5: begin
                r.st = 4'd9; r.hl = 1'b1;
                q.push_back(r);
                m_halt = 1'b1;
            end
            default: begin
                r.st = 4'd3;
                q.push_back(r);
            end
        endcase
        m_pc = np;
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", sample(), '0);
        ResetN = 1'b1;
    endtask

    task automatic run_model(input string name, input int n);
        obs_t exp, r;
        q.delete();
        m_pc = 7'd0;
        m_halt = 1'b0;
        q.push_back('0);
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) begin
                if (m_halt) begin
                    r = '0; r.st = 4'd9; r.pc = m_pc; r.hl = 1'b1;
                    q.push_back(r);
                end else begin
                    expand(rom[m_pc]);
                end
            end
            exp = q.pop_front();
            chk(name, sample(), exp);
            @(negedge clk);
        end
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 128; i++) rom[i] = w;
    endtask

    vec_t vecs[8];

    initial begin
        fill(16'h0000);
        vecs[0] = '{16'h2093, 4, mk(4'd5, 8'h09, 0, 1, 1, 4'd3, 4'd0, 4'd0, 3'd0, 0), 4'd1};
        vecs[1] = '{16'h3124, 3, mk(4'd7, 8'h00, 0, 0, 1, 4'd4, 4'd1, 4'd2, 3'd1, 0), 4'd1};
        vecs[2] = '{16'h4215, 3, mk(4'd8, 8'h00, 0, 0, 1, 4'd5, 4'd2, 4'd1, 3'd2, 0), 4'd1};
        vecs[3] = '{16'h1209, 3, mk(4'd6, 8'h09, 1, 0, 0, 4'd0, 4'd2, 4'd0, 3'd0, 0), 4'd1};
        vecs[4] = '{16'h5000, 3, mk(4'd9, 8'h00, 0, 0, 0, 4'd0, 4'd0, 4'd0, 3'd0, 1), 4'd9};
        vecs[5] = '{16'hF123, 3, mk(4'd3, 8'h00, 0, 0, 0, 4'd0, 4'd0, 4'd0, 3'd0, 0), 4'd1};
        vecs[6] = '{16'h0000, 3, mk(4'd3, 8'h00, 0, 0, 0, 4'd0, 4'd0, 4'd0, 3'd0, 0), 4'd1};
        vecs[7] = '{16'h6ABC, 3, mk(4'd3, 8'h00, 0, 0, 0, 4'd0, 4'd0, 4'd0, 3'd0, 0), 4'd1};

        // Single-instruction vectors: check the final execute cycle and the next state
        for (int v = 0; v < 8; v++) begin
            fill(16'h0000);
            rom[0] = vecs[v].ins;
            do_reset();
            repeat (vecs[v].cyc) @(negedge clk);
            chk($sformatf("vec%0d_exec", v), sample(), vecs[v].exp);
            @(negedge clk);
            chkv($sformatf("vec%0d_next", v), 32'(OutState), 32'(vecs[v].nxt));
        end

        // LOAD A/B, ADD then SUB, STORE back-to-back against the model
        fill(16'h0000);
        rom[0] = 16'h2093; rom[1] = 16'h3124; rom[2] = 16'h4215; rom[3] = 16'h1209;
        do_reset();
        run_model("seq", 20);

        // HALT held with further words in ROM, then reset pulse
        fill(16'h3124);
        rom[0] = 16'h5000;
        do_reset();
        run_model("halt_hold", 28);
        ResetN = 1'b0;
        #1;
        chk("halt_reset", sample(), '0);
        @(negedge clk);
        ResetN = 1'b1;

        // Reset mid LOAD_B: strobes must drop without a clock edge
        fill(16'h0000);
        rom[0] = 16'h2093;
        do_reset();
        repeat (4) @(negedge clk);
        chk("loadb_pre", sample(), mk(4'd5, 8'h09, 0, 1, 1, 4'd3, 4'd0, 4'd0, 3'd0, 0));
        #2;
        ResetN = 1'b0;
        #1;
        chk("loadb_async_rst", sample(), '0);
        @(negedge clk);
        ResetN = 1'b1;
        run_model("restart", 10);

        // PC wrap: NOOPs up to 127, HALT at 127 still increments PC to 0
        fill(16'h0000);
        rom[127] = 16'h5000;
        do_reset();
        run_model("wrap", 400);
        chkv("wrap_pc", 32'(PC_addr), 32'd0);
        chkv("wrap_halted", 32'(Halted), 32'd1);

        // Random programs (HALT excluded so the run keeps going)
        for (int i = 0; i < 128; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'h5) op = 4'h2;
            rom[i] = {op, 12'($urandom)};
        end
        do_reset();
        run_model("random", 900);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

The control unit is the initiator side of the processor datapath's control interface. It fetches 16-bit instructions from an external synchronous instruction ROM and decodes them. It then sequences the datapath control strobes (data-memory address/write, register-file addresses/write enable, write-back mux select, ALU select) through a Moore state machine. It sits beside the datapath in the processor top level and is its only driver.

## Interface
- PC_W, 7, program-counter width; ROM depth is 2^PC_W words.
- Clk  input  1  system clock; all state changes on rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- IR_in  input  16  instruction word from ROM; valid one cycle after PC_addr changes.
- PC_addr  output  PC_W  current program counter, drives ROM address.
- D_Addr  output  8  data-memory address.
- D_wr  output  1  data-memory write enable.
- RF_s  output  1  write-back select: 1 = data memory, 0 = ALU.
- RF_W_en  output  1  register-file write enable.
- RF_W_addr, RF_Ra_addr, RF_Rb_addr  output  4 each  register-file write/read addresses.
- Alu_s0  output  3  ALU function: 3'd1 add, 3'd2 subtract, 3'd0 idle.
- OutState  output  4  current state encoding, for debug display.
- Halted  output  1  high while in HALT.

## Operation
- Instruction format: opcode = IR[15:12].
  - NOOP 0000.
  - STORE 0001: Ra = IR[11:8], D_Addr = IR[7:0].
  - LOAD 0010: D_Addr = IR[11:4], Rw = IR[3:0].
  - ADD 0011 / SUB 0100: Ra = IR[11:8], Rb = IR[7:4], Rw = IR[3:0].
  - HALT 0101.
  - Opcodes 0110–1111 execute as NOOP.
- State encodings: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
- INIT -> FETCH unconditionally.
- FETCH -> DECODE. This state absorbs ROM read latency; PC_addr is held.
- DECODE:
  - IR <= IR_in; PC <= PC + 1 (mod 2^PC_W; 2^PC_W−1 wraps to 0).
  - Next state is chosen from IR_in[15:12]: NOOP, LOAD_A, STORE, ADD, SUB, or HALT.
- LOAD_A: D_Addr = IR[11:4], RF_s = 1, D_wr = 0. This state covers data-memory read latency. Next: LOAD_B.
- LOAD_B: same as LOAD_A, plus RF_W_en = 1 and RF_W_addr = IR[3:0]. Next: FETCH.
- STORE: D_wr = 1, D_Addr = IR[7:0], RF_Ra_addr = IR[11:8], RF_W_en = 0. Next: FETCH.
- ADD / SUB:
  - RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0].
  - RF_s = 0, RF_W_en = 1, Alu_s0 = 1 (ADD) or 2 (SUB).
  - Next: FETCH.
- NOOP: all strobes low. Next: FETCH.
- HALT: all strobes low, Halted = 1. Stays in HALT until ResetN is asserted; PC frozen.
- Outputs are Moore: a function of state and the IR register only, never IR_in.
- In every state, any strobe or address not listed above is 0.

## Timing
- Reset (ResetN = 0, asynchronous, immediate):
  - State = INIT, PC = 0, IR = 0.
  - All outputs 0: D_wr, RF_W_en, RF_s, all addresses, Alu_s0, Halted; OutState = 0.
- First FETCH occurs in the 2nd cycle after ResetN deasserts.
- Cycles per instruction:
  - NOOP, STORE, ADD, SUB: 3 (FETCH, DECODE, execute).
  - LOAD: 4.
  - HALT: 2 cycles to enter.
- Write strobes (D_wr, RF_W_en) are high for exactly one cycle per instruction and are never high in INIT, FETCH, DECODE, or HALT.
- PC increments exactly once per instruction, on the DECODE edge.
- Reset asserted mid-instruction (e.g. in LOAD_B or STORE): strobes drop in the same cycle with no clock edge needed; the instruction is abandoned and restarts from PC = 0.
- A HALT instruction at address 2^PC_W−1 still increments PC (wraps to 0) before halting.

## Test plan
- Reset: hold ResetN = 0 with Clk running.
  - Required: all outputs 0, OutState = 0.
  - After release: OutState sequence 0,1,2 and PC_addr 0 -> 1 on the DECODE edge.
- LOAD 16'h2093: OutState 4 then 5.
  - Both states: D_Addr = 8'h09, RF_s = 1.
  - RF_W_en = 1 only in state 5, with RF_W_addr = 3.
  - Next state is FETCH.
- ADD 16'h3124 then SUB 16'h4215:
  - ADD state: Ra = 1, Rb = 2, Rw = 4, Alu_s0 = 1, RF_s = 0, RF_W_en = 1.
  - SUB state: Ra = 2, Rb = 1, Rw = 5, Alu_s0 = 2.
  - Each instruction takes 3 cycles.
- STORE 16'h1209: D_wr = 1 for one cycle, D_Addr = 8'h09, RF_Ra_addr = 2, RF_W_en = 0.
- HALT 16'h5000 followed by further ROM words:
  - Halted = 1 and OutState = 9, held for 20+ cycles.
  - PC_addr frozen; no strobes.
  - ResetN pulse returns to INIT.
- Opcode 16'hF123: treated as NOOP, all strobes 0, PC advances.
- Reset asserted during LOAD_B: RF_W_en falls before the next Clk edge.
- Run 2^PC_W NOOPs: PC_addr wraps from 127 to 0.
